// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALUOp codes, mux selects and the decoded control bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_BNE   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_ORI   = 3'b110;

  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // R-type functs the ALU controller implements: add..nor, slt, sltu.
  function automatic logic funct_ok(input logic [5:0] funct);
    case (funct)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011: funct_ok = 1'b1;
      default:              funct_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Combinational decode of FSM state (plus opcode, zero flag and memory ready)
// into the datapath control bundle.
import multicycle_ctrl_pkg::*;

module mc_ctrl_out_dec (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_RTYPE;
      end
      // R-type code held through write-back so the ALU controller stays steady
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        case (op)
          OP_ORI:  ctrl.alu_op = ALU_ORI;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      I_WB: ctrl.reg_write = 1'b1;
      // bne's ALU code raises zero on inequality, so both branches take on zero
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.alu_op    = (op == OP_BNE) ? ALU_BNE : ALU_SUB;
        ctrl.pc_write  = zero;
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next-state, reset gating.
// Optional perf counters enabled by MULTICYCLE_CTRL_PERF_EN.
import multicycle_ctrl_pkg::*;

module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        illegal_o,
  output logic [3:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  state_t state, state_nxt;
  logic   illegal;
  ctrl_t  dec_ctrl, ctrl;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    case (state)
      FETCH:    if (mem_ready_i) state_nxt = DECODE;
      DECODE: begin
        case (op_i)
          OP_RTYPE: begin
            if (funct_ok(funct_i)) state_nxt = R_EXEC;
            else begin
              state_nxt = FETCH;
              illegal   = 1'b1;
            end
          end
          OP_LW, OP_SW:            state_nxt = MEM_ADDR;
          OP_ADDI, OP_ORI, OP_LUI: state_nxt = I_EXEC;
          OP_BEQ, OP_BNE:          state_nxt = BRANCH;
          OP_J:                    state_nxt = JUMP;
          default: begin
            state_nxt = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEM_ADDR: state_nxt = (op_i == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready_i) state_nxt = MEM_WB;
      MEM_WB:   state_nxt = FETCH;
      MEM_WR:   if (mem_ready_i) state_nxt = FETCH;
      R_EXEC:   state_nxt = R_WB;
      R_WB:     state_nxt = FETCH;
      I_EXEC:   state_nxt = I_WB;
      I_WB:     state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      JUMP:     state_nxt = FETCH;
      default:  state_nxt = FETCH;
    endcase
  end

  mc_ctrl_out_dec u_dec (
    .state     (state),
    .op        (op_i),
    .zero      (zero_i),
    .mem_ready (mem_ready_i),
    .ctrl      (dec_ctrl)
  );

  // Reset is applied to the outputs combinationally, ahead of the state edge.
  always_comb begin
    ctrl = dec_ctrl;
    if (!rst_i) begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
    end
  end

  assign pc_write_o   = ctrl.pc_write;
  assign ir_write_o   = ctrl.ir_write;
  assign iord_o       = ctrl.iord;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign pc_src_o     = ctrl.pc_src;
  assign illegal_o    = illegal & rst_i;
  assign state_o      = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire, stall;

  assign retire = (state inside {MEM_WB, R_WB, I_WB, BRANCH, JUMP}) ||
                  (state == MEM_WR && mem_ready_i);
  assign stall  = (state inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      instr_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (retire) instr_cnt_o <= instr_cnt_o + 32'd1;
      if (stall)  stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
